// File: rtl/twos_pkg.sv
// Shared definitions for the two's-complement streaming unit: operation modes and MIN helper.
package twos_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_SMAG = 2'b11;

  // Most-negative two's-complement value for a given width (up to 64 bits).
  function automatic logic [63:0] min_val(input int unsigned width);
    return 64'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/twos_op_core.sv
// Combinational operation core: pass / negate / abs / sign-magnitude with overflow flag.
// Build option TWOS_SAT_EN: overflowing results saturate instead of wrapping.
module twos_op_core
  import twos_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [1:0]       mode_i,
  input  logic             is_min_i,
  output logic [WIDTH-1:0] y_c_o,
  output logic             ovf_c_o
);

`ifdef TWOS_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  logic [WIDTH-1:0] neg;
  logic [WIDTH-1:0] mag;

  always_comb begin
    neg     = ~x_i + WIDTH'(1);
    mag     = x_i[WIDTH-1] ? neg : x_i;
    y_c_o   = x_i;
    ovf_c_o = 1'b0;
    unique case (mode_i)
      MODE_PASS: y_c_o = x_i;
      MODE_NEG:  y_c_o = neg;
      MODE_ABS:  y_c_o = mag;
      MODE_SMAG: y_c_o = {x_i[WIDTH-1], mag[WIDTH-2:0]};
      default:   y_c_o = x_i;
    endcase
    // Only MIN has no representable negation/magnitude.
    ovf_c_o = is_min_i && (mode_i != MODE_PASS);
`ifdef TWOS_SAT_EN
    if (ovf_c_o) begin
      y_c_o = (mode_i == MODE_SMAG) ? '1 : MAX_POS;
    end
`endif
  end

endmodule

// File: rtl/twos_complement_stream.sv
// Two-stage valid/ready pipeline around twos_op_core with a saturating overflow counter.
// Optional build macro TWOS_SAT_EN selects saturating results (see twos_op_core).
module twos_complement_stream
  import twos_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             ovf_clr
);

  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(min_val(WIDTH));

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [1:0]       s1_mode_q,  s1_mode_d;
  logic             s1_min_q,   s1_min_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q,  s2_data_d;
  logic             s2_ovf_q,   s2_ovf_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             s2_load;
  logic [WIDTH-1:0] op_y;
  logic             op_ovf;

  twos_op_core #(.WIDTH(WIDTH)) u_core (
    .x_i      (s1_data_q),
    .mode_i   (s1_mode_q),
    .is_min_i (s1_min_q),
    .y_c_o    (op_y),
    .ovf_c_o  (op_ovf)
  );

  // Next-state: stage k loads when empty or when stage k+1 takes its content.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_min_d   = s1_min_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_ovf_d   = s2_ovf_q;
    cnt_d      = cnt_q;

    s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = !rst && (!s1_valid_q || s2_load);

    if (!s1_valid_q || s2_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_mode_d = in_mode;
        s1_min_d  = (in_data == MIN_VAL);
      end
    end

    // Output payload only changes when a new sample is taken, so it holds under stall.
    if (!s2_valid_q || out_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = op_y;
        s2_ovf_d  = op_ovf;
      end
    end

    if (ovf_clr) begin
      cnt_d = '0;
    end else if (s2_valid_q && out_ready && s2_ovf_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= MODE_PASS;
      s1_min_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_ovf_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s1_min_q   <= s1_min_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_ovf_q   <= s2_ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_ovf   = s2_ovf_q;
  assign ovf_count = cnt_q;

endmodule
